// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_rd_ctrl                                                  |
// | Purpose  : Read-domain controller of an asynchronous FIFO. Brings the    |
// |            gray write pointer into rclk through a 2-flop synchronizer,   |
// |            keeps the binary and gray read pointers, generates the        |
// |            registered empty flag and the memory read address, and        |
// |            registers the word read out of the dual-port memory.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   rclk        in   read clock, all flops rising-edge                     |
// |   r_rst_n     in   asynchronous active-low reset                         |
// |   wptr        in   gray write pointer from the write clock domain        |
// |   r_en        in   read request from the consumer                        |
// |   mem_rdata   in   asynchronous-read memory data at raddr                |
// |   raddr       out  binary memory read address                           |
// |   rptr        out  registered gray read pointer (to write-side sync)     |
// |   wptr_sync   out  write pointer after the 2-flop synchronizer           |
// |   empty       out  registered empty flag                                |
// |   data_out    out  registered read data                                 |
// |   data_valid  out  1-cycle pulse, data_out holds a newly read word       |
// |   underflow   out  1-cycle pulse, read requested while empty             |
// |   rd_level    out  fill level seen from the read side (RD_LEVEL_EN only) |
// +--------------------------------------------------------------------------+
// | Configuration                                                            |
// |   RD_LEVEL_EN : when defined, adds rd_level = gray2bin(wptr_sync) - rbin |
// +--------------------------------------------------------------------------+
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 9
) (
  input  logic                  rclk,
  input  logic                  r_rst_n,
  input  logic [PTR_WIDTH:0]    wptr,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [PTR_WIDTH-1:0]  raddr,
  output logic [PTR_WIDTH:0]    rptr,
  output logic [PTR_WIDTH:0]    wptr_sync,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  underflow
`ifdef RD_LEVEL_EN
  ,
  output logic [PTR_WIDTH:0]    rd_level
`endif
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  // Synchronizer stages
  logic [PTR_WIDTH:0]    wq1_q;
  logic [PTR_WIDTH:0]    wptr_sync_q;

  // Read pointers, flags and data register
  logic [PTR_WIDTH:0]    rbin_q, rbin_d;
  logic [PTR_WIDTH:0]    rptr_q, rptr_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  underflow_q, underflow_d;
  logic                  accept;

  function automatic logic [PTR_WIDTH:0] bin2gray(input logic [PTR_WIDTH:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // ------------------------------------------------------------------------
  // Two-flop synchronizer for the gray write pointer. Only one bit of wptr
  // changes per write, so a metastable capture resolves to either the old
  // or the new pointer value, never a mix.
  // ------------------------------------------------------------------------
  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      wq1_q       <= '0;
      wptr_sync_q <= '0;
    end else begin
      wq1_q       <= wptr;
      wptr_sync_q <= wq1_q;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic for pointers, flags and read data
  // ------------------------------------------------------------------------
  always_comb begin
    accept       = r_en & ~empty_q;
    underflow_d  = r_en & empty_q;
    data_valid_d = accept;
    data_out_d   = data_out_q;
    rbin_d       = rbin_q;

    if (accept) begin
      rbin_d     = rbin_q + PTR_ONE;
      // The memory is read asynchronously at the current raddr, so the word
      // captured here is the one belonging to the pre-increment pointer.
      data_out_d = mem_rdata;
    end

    rptr_d = bin2gray(rbin_d);

    // Comparing against the post-read pointer lets empty assert in the same
    // cycle the last word is taken, so a following r_en cannot over-read.
    // The synchronized write pointer lags the true one, which only ever
    // makes the flag pessimistic.
    empty_d = (rptr_d == wptr_sync_q);
  end

  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      empty_q      <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      empty_q      <= empty_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      underflow_q  <= underflow_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign raddr      = rbin_q[PTR_WIDTH-1:0];
  assign rptr       = rptr_q;
  assign wptr_sync  = wptr_sync_q;
  assign empty      = empty_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign underflow  = underflow_q;

`ifdef RD_LEVEL_EN
  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] gray);
    logic [PTR_WIDTH:0] bin;
    bin[PTR_WIDTH] = gray[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Modulo subtraction of the extra-MSB pointers yields 0..DEPTH directly.
  assign rd_level = gray2bin(wptr_sync_q) - rbin_q;
`endif

endmodule
`default_nettype wire
